// File: rtl/memory_moc_responder.sv
// Memory-side responder for the MFA/MOC handshake: captures a request, waits
// WAIT_CYCLES edges, performs a big-endian byte/half/word access and holds MOC.
module memory_moc_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MFA,
    input  logic              RW,
    input  logic [1:0]        DT,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              MOC
);

    localparam int unsigned Depth    = 2 ** ADDR_W;
    localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       data_out_q, data_out_d;
    logic              rw_q;
    logic [1:0]        dt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [7:0] mem [Depth];

    logic              capture, access;
    logic              op_rw;
    logic [1:0]        op_dt;
    logic [ADDR_W-1:0] op_addr, base;
    logic [31:0]       op_data, wdata_left, rdata;
    logic [3:0]        byte_mask, lane_en;
    logic [ADDR_W-1:0] lane_addr [4];
    logic [7:0]        lane_wdata [4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_q    <= 1'b0;
            dt_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            rw_q    <= RW;
            dt_q    <= DT;
            addr_q  <= address;
            wdata_q <= data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        access  = 1'b0;
        case (state_q)
            StIdle: begin
                if (MFA) begin
                    capture = 1'b1;
                    cnt_d   = WaitInit;
                    if (WAIT_CYCLES == 0) begin
                        access  = 1'b1;
                        state_d = StAck;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!MFA) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        access  = 1'b1;
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                if (!MFA) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // With zero wait the access happens on the capture edge, so bypass the regs.
    always_comb begin
        op_rw   = (state_q == StIdle) ? RW      : rw_q;
        op_dt   = (state_q == StIdle) ? DT      : dt_q;
        op_addr = (state_q == StIdle) ? address : addr_q;
        op_data = (state_q == StIdle) ? data_in : wdata_q;
        case (op_dt)
            2'b00: begin
                base       = op_addr;
                byte_mask  = 4'b0001;
                wdata_left = {op_data[7:0], 24'h0};
            end
            2'b01: begin
                base       = {op_addr[ADDR_W-1:1], 1'b0};
                byte_mask  = 4'b0011;
                wdata_left = {op_data[15:0], 16'h0};
            end
            default: begin
                base       = {op_addr[ADDR_W-1:2], 2'b00};
                byte_mask  = 4'b1111;
                wdata_left = op_data;
            end
        endcase
        for (int k = 0; k < 4; k++) begin
            lane_addr[k]  = base + ADDR_W'(k);
            lane_wdata[k] = wdata_left[31-8*k -: 8];
        end
        lane_en = (access && !op_rw && reset) ? byte_mask : 4'b0000;
        case (op_dt)
            2'b00:   rdata = {24'h0, mem[lane_addr[0]]};
            2'b01:   rdata = {16'h0, mem[lane_addr[0]], mem[lane_addr[1]]};
            default: rdata = {mem[lane_addr[0]], mem[lane_addr[1]],
                              mem[lane_addr[2]], mem[lane_addr[3]]};
        endcase
    end

    always_comb begin
        data_out_d = data_out_q;
        if (access && op_rw) data_out_d = rdata;
        if (state_q == StAck && !MFA) data_out_d = '0;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) mem[lane_addr[k]] <= lane_wdata[k];
        end
    end

    always_comb begin
        MOC      = (state_q == StAck);
        data_out = data_out_q;
    end

endmodule

// File: tb/tb_memory_moc_responder.sv
// Bench for memory_moc_responder: directed handshake scenarios plus randomized
// traffic checked against a byte-array memory model.
module tb_memory_moc_responder;

    localparam int unsigned WAIT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MFA = 1'b0, RW = 1'b0;
    logic [1:0]  DT = 2'b00;
    logic [7:0]  address = '0;
    logic [31:0] data_in = '0, data_out;
    logic        MOC;

    logic        MFA0 = 1'b0, RW0 = 1'b0;
    logic [1:0]  DT0 = 2'b10;
    logic [7:0]  address0 = '0;
    logic [31:0] data_in0 = '0, data_out0;
    logic        MOC0;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] mm [256];

    memory_moc_responder #(.ADDR_W(8), .WAIT_CYCLES(WAIT), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset), .MFA(MFA), .RW(RW), .DT(DT), .address(address),
        .data_in(data_in), .data_out(data_out), .MOC(MOC)
    );

    memory_moc_responder #(.ADDR_W(8), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .reset(reset), .MFA(MFA0), .RW(RW0), .DT(DT0), .address(address0),
        .data_in(data_in0), .data_out(data_out0), .MOC(MOC0)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned size_of(input logic [1:0] dt);
        return (dt == 2'b00) ? 1 : ((dt == 2'b01) ? 2 : 4);
    endfunction

    task automatic model_write(input logic [1:0] dt, input logic [7:0] a, input logic [31:0] d);
        int unsigned s = size_of(dt);
        int unsigned b = int'(a) - (int'(a) % s);
        for (int i = 0; i < s; i++) mm[8'((b + i) % 256)] = 8'(d >> (8 * (s - 1 - i)));
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] dt, input logic [7:0] a);
        int unsigned s = size_of(dt);
        int unsigned b = int'(a) - (int'(a) % s);
        logic [31:0] v = '0;
        for (int i = 0; i < s; i++) v = (v << 8) | 32'(mm[8'((b + i) % 256)]);
        return v;
    endfunction

    // One full handshake; operands are scrambled after capture to prove they are latched.
    task automatic txn(input logic rw, input logic [1:0] dt, input logic [7:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
        int n;
        MFA = 1'b1; RW = rw; DT = dt; address = a; data_in = d;
        @(negedge clk);
        RW = ~rw; DT = 2'($urandom); address = 8'($urandom); data_in = $urandom;
        n = 0;
        while (!MOC && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(WAIT));
        rd = data_out;
        MFA = 1'b0;
        @(negedge clk);
        check("moc_clear", {31'b0, MOC}, 32'd0);
        check("dout_clear", data_out, 32'd0);
    endtask

    initial begin
        logic [31:0] rd, exp, d;
        logic [1:0]  dt;
        logic [7:0]  a;
        logic        rw;
        int          n;

        // Reset held with a pending request
        MFA = 1'b1; RW = 1'b0; DT = 2'b10; address = 8'h10; data_in = 32'hDEADBEEF;
        repeat (3) begin
            @(negedge clk);
            check("rst_moc", {31'b0, MOC}, 32'd0);
            check("rst_dout", data_out, 32'd0);
        end
        reset = 1'b1;
        txn(1'b0, 2'b10, 8'h10, 32'hDEADBEEF, rd);
        txn(1'b1, 2'b10, 8'h10, 32'h0, rd);
        check("rd_word10", rd, 32'hDEADBEEF);
        txn(1'b1, 2'b00, 8'h11, 32'h0, rd);
        check("rd_byte11", rd, 32'h000000AD);

        txn(1'b0, 2'b00, 8'h13, 32'hFFFFFF5A, rd);
        txn(1'b1, 2'b10, 8'h10, 32'h0, rd);
        check("byte_merge", rd, 32'hDEADBE5A);
        txn(1'b0, 2'b01, 8'h11, 32'hAAAA1234, rd);
        txn(1'b1, 2'b11, 8'h12, 32'h0, rd);
        check("half_align", rd, 32'h1234BE5A);

        // Abort: MFA drops right after capture
        txn(1'b0, 2'b10, 8'h20, 32'h01020304, rd);
        MFA = 1'b1; RW = 1'b0; DT = 2'b10; address = 8'h20; data_in = 32'hFFFFFFFF;
        @(negedge clk);
        MFA = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_moc", {31'b0, MOC}, 32'd0);
        end
        txn(1'b1, 2'b10, 8'h20, 32'h0, rd);
        check("abort_mem", rd, 32'h01020304);

        // Hold MFA past MOC
        MFA = 1'b1; RW = 1'b1; DT = 2'b10; address = 8'h10;
        @(negedge clk);
        n = 0;
        while (!MOC && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_latency", 32'(n), 32'(WAIT));
        repeat (5) begin
            RW = 1'b0; address = 8'($urandom); data_in = $urandom; DT = 2'($urandom);
            @(negedge clk);
            check("hold_moc", {31'b0, MOC}, 32'd1);
            check("hold_dout", data_out, 32'h1234BE5A);
        end
        MFA = 1'b0;
        @(negedge clk);
        check("release_moc", {31'b0, MOC}, 32'd0);
        txn(1'b1, 2'b00, 8'h12, 32'h0, rd);
        check("reraise_rd", rd, 32'h000000BE);

        // Reset pulsed during WAIT of a write
        MFA = 1'b1; RW = 1'b0; DT = 2'b10; address = 8'h10; data_in = 32'hCAFEF00D;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rstw_moc", {31'b0, MOC}, 32'd0);
        MFA = 1'b0;
        @(negedge clk);
        check("rstw_moc2", {31'b0, MOC}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        txn(1'b1, 2'b10, 8'h10, 32'h0, rd);
        check("rstw_mem", rd, 32'h1234BE5A);

        // Zero-wait instance: MOC rises on the capture edge
        MFA0 = 1'b1; RW0 = 1'b0; DT0 = 2'b10; address0 = 8'h40; data_in0 = 32'h55AA33CC;
        @(negedge clk);
        check("w0_moc", {31'b0, MOC0}, 32'd1);
        MFA0 = 1'b0;
        @(negedge clk);
        check("w0_clear", {31'b0, MOC0}, 32'd0);
        MFA0 = 1'b1; RW0 = 1'b1;
        @(negedge clk);
        check("w0_rd_moc", {31'b0, MOC0}, 32'd1);
        check("w0_rd", data_out0, 32'h55AA33CC);
        MFA0 = 1'b0;
        @(negedge clk);

        // Randomized traffic against the model, after filling memory
        for (int i = 0; i < 256; i += 4) begin
            d = $urandom;
            txn(1'b0, 2'b10, 8'(i), d, rd);
            model_write(2'b10, 8'(i), d);
        end
        for (int i = 0; i < 300; i++) begin
            rw = 1'($urandom);
            dt = 2'($urandom);
            a  = 8'($urandom);
            d  = $urandom;
            txn(rw, dt, a, d, rd);
            if (rw) begin
                exp = model_read(dt, a);
                check("rand_rd", rd, exp);
            end else begin
                model_write(dt, a, d);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
